// File: rtl/sram_march_bist_if.sv
// Pin bundle between the March C- BIST controller and a single-port SRAM macro.
interface sram_march_bist_if #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 64,
    parameter int WMASK_WIDTH = 2
);
    logic                   sram_we;
    logic [WMASK_WIDTH-1:0] sram_wmask;
    logic [ADDR_WIDTH-1:0]  sram_addr;
    logic [DATA_WIDTH-1:0]  sram_din;
    logic [DATA_WIDTH-1:0]  sram_dout;

    modport master (
        output sram_we, sram_wmask, sram_addr, sram_din,
        input  sram_dout
    );
    modport slave (
        input  sram_we, sram_wmask, sram_addr, sram_din,
        output sram_dout
    );
endinterface

// File: rtl/sram_march_bist.sv
// March C- BIST controller for a single-port SRAM with registered dout.
// Issues one op per cycle, compares reads one cycle later, logs the first mismatch.
module sram_march_bist #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 64,
    parameter int WMASK_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pattern,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_element,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [DATA_WIDTH-1:0] fail_expected,
    sram_march_bist_if.master     sram
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

    state_t                 r_state;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_fail;
    logic [ADDR_WIDTH-1:0]  r_fail_addr;
    logic [2:0]             r_fail_elem;
    logic [DATA_WIDTH-1:0]  r_fail_data;
    logic [DATA_WIDTH-1:0]  r_fail_exp;
    logic [DATA_WIDTH-1:0]  r_pat;
    logic [2:0]             r_elem;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_op;
    logic                   r_last;
    logic                   r_we;
    logic [WMASK_WIDTH-1:0] r_wmask;
    logic [ADDR_WIDTH-1:0]  r_sram_addr;
    logic [DATA_WIDTH-1:0]  r_din;
    logic                   r_rd;
    logic [DATA_WIDTH-1:0]  r_rd_exp;
    logic [2:0]             r_rd_elem;
    logic                   r_cmp_valid;
    logic [DATA_WIDTH-1:0]  r_cmp_exp;
    logic [ADDR_WIDTH-1:0]  r_cmp_addr;
    logic [2:0]             r_cmp_elem;

    logic                   w_accept;
    logic                   w_issue;
    logic [2:0]             w_elem;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic                   w_op;
    logic [DATA_WIDTH-1:0]  w_pat;
    logic                   w_desc;
    logic                   w_two;
    logic                   w_write;
    logic                   w_inv;
    logic [DATA_WIDTH-1:0]  w_data;
    logic                   w_op_last;
    logic                   w_addr_end;
    logic [2:0]             w_n_elem;
    logic [ADDR_WIDTH-1:0]  w_n_addr;
    logic                   w_n_op;
    logic                   w_n_last;

    // The accepting edge already issues op 0 so done lands 10N+1 edges later.
    assign w_accept = start && (r_state == IDLE || r_state == DONE);
    assign w_issue  = w_accept || (r_state == RUN && !r_last);
    assign w_elem   = w_accept ? 3'd0 : r_elem;
    assign w_addr   = w_accept ? '0 : r_addr;
    assign w_op     = w_accept ? 1'b0 : r_op;
    assign w_pat    = w_accept ? pattern : r_pat;

    always_comb begin
        w_desc     = (w_elem == 3'd3) || (w_elem == 3'd4);
        w_two      = (w_elem != 3'd0) && (w_elem != 3'd5);
        w_write    = (w_elem == 3'd0) || (w_two && w_op);
        w_inv      = w_write ? (w_elem == 3'd1 || w_elem == 3'd3)
                             : (w_elem == 3'd2 || w_elem == 3'd4);
        w_data     = w_inv ? ~w_pat : w_pat;
        w_op_last  = !w_two || w_op;
        w_addr_end = w_desc ? (w_addr == '0) : (w_addr == ADDR_MAX);
        w_n_elem   = w_elem;
        w_n_addr   = w_addr;
        w_n_op     = 1'b0;
        w_n_last   = 1'b0;
        if (!w_op_last) begin
            w_n_op = 1'b1;
        end else if (!w_addr_end) begin
            w_n_addr = w_desc ? w_addr - ADDR_WIDTH'(1) : w_addr + ADDR_WIDTH'(1);
        end else if (w_elem == 3'd5) begin
            w_n_last = 1'b1;
        end else begin
            w_n_elem = w_elem + 3'd1;
            w_n_addr = (w_elem == 3'd2 || w_elem == 3'd3) ? ADDR_MAX : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_fail_data <= '0;
            r_fail_exp  <= '0;
            r_pat       <= '0;
            r_elem      <= '0;
            r_addr      <= '0;
            r_op        <= 1'b0;
            r_last      <= 1'b0;
            r_we        <= 1'b0;
            r_wmask     <= '0;
            r_sram_addr <= '0;
            r_din       <= '0;
            r_rd        <= 1'b0;
            r_rd_exp    <= '0;
            r_rd_elem   <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_exp   <= '0;
            r_cmp_addr  <= '0;
            r_cmp_elem  <= '0;
        end else begin
            // SRAM latches the read this cycle; its dout is checked next cycle.
            r_cmp_valid <= r_rd;
            r_cmp_exp   <= r_rd_exp;
            r_cmp_addr  <= r_sram_addr;
            r_cmp_elem  <= r_rd_elem;
            if (w_issue) begin
                r_we        <= w_write;
                r_wmask     <= w_write ? '1 : '0;
                r_sram_addr <= w_addr;
                r_din       <= w_write ? w_data : '0;
                r_rd        <= !w_write;
                r_rd_exp    <= w_data;
                r_rd_elem   <= w_elem;
                r_elem      <= w_n_elem;
                r_addr      <= w_n_addr;
                r_op        <= w_n_op;
                r_last      <= w_n_last;
                r_pat       <= w_pat;
            end else begin
                r_we    <= 1'b0;
                r_wmask <= '0;
                r_din   <= '0;
                r_rd    <= 1'b0;
            end
            if (r_cmp_valid && !r_fail && sram.sram_dout != r_cmp_exp) begin
                r_fail      <= 1'b1;
                r_fail_addr <= r_cmp_addr;
                r_fail_elem <= r_cmp_elem;
                r_fail_data <= sram.sram_dout;
                r_fail_exp  <= r_cmp_exp;
            end
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state     <= RUN;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_fail      <= 1'b0;
                        r_fail_addr <= '0;
                        r_fail_elem <= '0;
                        r_fail_data <= '0;
                        r_fail_exp  <= '0;
                    end
                end
                RUN: begin
                    if (r_last) r_state <= DRAIN;
                end
                DRAIN: begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign fail            = r_fail;
    assign fail_addr       = r_fail_addr;
    assign fail_element    = r_fail_elem;
    assign fail_data       = r_fail_data;
    assign fail_expected   = r_fail_exp;
    assign sram.sram_we    = r_we;
    assign sram.sram_wmask = r_wmask;
    assign sram.sram_addr  = r_sram_addr;
    assign sram.sram_din   = r_din;
endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: N=8 and N=1024 instances, each with a behavioural SRAM.
module tb_sram_march_bist;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        use1k;
    logic        fault_en;
    logic [63:0] pattern;
    logic        start8;
    logic        start1k;

    assign start8  = start & ~use1k;
    assign start1k = start & use1k;

    sram_march_bist_if #(.ADDR_WIDTH(3), .DATA_WIDTH(64), .WMASK_WIDTH(2)) if8 ();
    sram_march_bist_if #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .WMASK_WIDTH(2)) if1k ();

    logic        busy8, done8, fail8;
    logic [2:0]  faddr8, felem8;
    logic [63:0] fdata8, fexp8;
    logic        busy1k, done1k, fail1k;
    logic [9:0]  faddr1k;
    logic [2:0]  felem1k;
    logic [63:0] fdata1k, fexp1k;

    sram_march_bist #(.ADDR_WIDTH(3), .DATA_WIDTH(64), .WMASK_WIDTH(2)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .pattern(pattern),
        .busy(busy8), .done(done8), .fail(fail8), .fail_addr(faddr8),
        .fail_element(felem8), .fail_data(fdata8), .fail_expected(fexp8),
        .sram(if8.master)
    );

    sram_march_bist #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .WMASK_WIDTH(2)) u_dut1k (
        .clk(clk), .rst(rst), .start(start1k), .pattern(pattern),
        .busy(busy1k), .done(done1k), .fail(fail1k), .fail_addr(faddr1k),
        .fail_element(felem1k), .fail_data(fdata1k), .fail_expected(fexp1k),
        .sram(if1k.master)
    );

    // SRAM models: registered dout; addr 5 of the small one can have bit 40 stuck-at-0.
    logic [63:0] mem8 [8];
    logic [63:0] mem1k [1024];
    localparam logic [63:0] STUCK_MASK = ~(64'd1 << 40);

    always @(posedge clk) begin
        if (if8.sram_we) begin
            for (int w = 0; w < 2; w++)
                if (if8.sram_wmask[w])
                    mem8[if8.sram_addr][w*32 +: 32] <= if8.sram_din[w*32 +: 32];
        end else begin
            if8.sram_dout <= mem8[if8.sram_addr] &
                ((fault_en && if8.sram_addr == 3'd5) ? STUCK_MASK : 64'hFFFF_FFFF_FFFF_FFFF);
        end
    end

    always @(posedge clk) begin
        if (if1k.sram_we) begin
            for (int w = 0; w < 2; w++)
                if (if1k.sram_wmask[w])
                    mem1k[if1k.sram_addr][w*32 +: 32] <= if1k.sram_din[w*32 +: 32];
        end else begin
            if1k.sram_dout <= mem1k[if1k.sram_addr];
        end
    end

    logic        m_we, m_busy, m_done, m_fail;
    logic [1:0]  m_wmask;
    logic [9:0]  m_addr, m_faddr;
    logic [2:0]  m_felem;
    logic [63:0] m_din, m_fdata, m_fexp;

    always_comb begin
        if (use1k) begin
            m_we = if1k.sram_we; m_wmask = if1k.sram_wmask;
            m_addr = if1k.sram_addr; m_din = if1k.sram_din;
            m_busy = busy1k; m_done = done1k; m_fail = fail1k;
            m_faddr = faddr1k; m_felem = felem1k;
            m_fdata = fdata1k; m_fexp = fexp1k;
        end else begin
            m_we = if8.sram_we; m_wmask = if8.sram_wmask;
            m_addr = {7'd0, if8.sram_addr}; m_din = if8.sram_din;
            m_busy = busy8; m_done = done8; m_fail = fail8;
            m_faddr = {7'd0, faddr8}; m_felem = felem8;
            m_fdata = fdata8; m_fexp = fexp8;
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  wmask;
        logic [9:0]  addr;
        logic [63:0] din;
    } op_t;

    typedef struct {
        logic        big;
        logic [63:0] pat;
        logic        fault;
        logic        mid;
        logic        e_fail;
        logic [9:0]  e_addr;
        logic [2:0]  e_elem;
        logic [63:0] e_data;
        logic [63:0] e_exp;
    } vec_t;

    op_t  q_ops [$];
    vec_t q_res [$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void check(string nm, int idx, logic [159:0] act, logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic big, logic [63:0] pat, logic fault, logic mid,
                                logic ef, logic [9:0] ea, logic [2:0] ee,
                                logic [63:0] ed, logic [63:0] ex);
        vec_t v;
        v.big = big; v.pat = pat; v.fault = fault; v.mid = mid;
        v.e_fail = ef; v.e_addr = ea; v.e_elem = ee; v.e_data = ed; v.e_exp = ex;
        return v;
    endfunction

    task automatic el(input int n, input bit desc, input bit rd, input bit wr,
                      input logic [63:0] wd);
        int a;
        for (int j = 0; j < n; j++) begin
            a = desc ? n - 1 - j : j;
            if (rd) q_ops.push_back('{1'b0, 2'b00, 10'(a), 64'd0});
            if (wr) q_ops.push_back('{1'b1, 2'b11, 10'(a), wd});
        end
    endtask

    task automatic gen_ops(input int n, input logic [63:0] p);
        el(n, 1'b0, 1'b0, 1'b1, p);
        el(n, 1'b0, 1'b1, 1'b1, ~p);
        el(n, 1'b0, 1'b1, 1'b1, p);
        el(n, 1'b1, 1'b1, 1'b1, ~p);
        el(n, 1'b1, 1'b1, 1'b1, p);
        el(n, 1'b0, 1'b1, 1'b0, p);
    endtask

    task automatic run_vec(input vec_t v);
        int   n;
        int   i;
        op_t  o;
        vec_t r;
        use1k    = v.big;
        fault_en = v.fault;
        pattern  = v.pat;
        n        = v.big ? 1024 : 8;
        q_ops.delete();
        gen_ops(n, v.pat);
        q_res.push_back(v);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        pattern = ~v.pat;
        i = 0;
        forever begin
            @(negedge clk);
            if (i == 0) begin
                check("busy_on", i, 160'(m_busy), 160'(1));
                check("fail_clr", i, {m_fail, m_faddr, m_felem, m_fdata, m_fexp}, 160'(0));
            end
            if (q_ops.size() != 0) begin
                o = q_ops.pop_front();
                check("op", i, {m_we, m_wmask, m_addr, m_din}, {o.we, o.wmask, o.addr, o.din});
            end
            if (v.mid && i == 20) start = 1'b1;
            if (i == 21) start = 1'b0;
            if (m_done || i > 10 * n + 20) break;
            @(posedge clk);
            i++;
        end
        check("latency", n, 160'(i), 160'(10 * n + 1));
        check("ops_left", n, 160'(q_ops.size()), 160'(0));
        check("busy_off", n, 160'(m_busy), 160'(0));
        r = q_res.pop_front();
        check("fail", n, 160'(m_fail), 160'(r.e_fail));
        check("fail_addr", n, 160'(m_faddr), 160'(r.e_addr));
        check("fail_elem", n, 160'(m_felem), 160'(r.e_elem));
        check("fail_data", n, 160'(m_fdata), 160'(r.e_data));
        check("fail_exp", n, 160'(m_fexp), 160'(r.e_exp));
    endtask

    vec_t vt [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = mk(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 10'd0, 3'd0, 64'd0, 64'd0);
        vt[1] = mk(1'b0, 64'hA5A5_5A5A_F0F0_0F0F, 1'b0, 1'b1, 1'b0, 10'd0, 3'd0, 64'd0, 64'd0);
        vt[2] = mk(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 10'd5, 3'd2,
                   64'hFFFF_FEFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        vt[3] = mk(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 10'd0, 3'd0, 64'd0, 64'd0);
        vt[4] = mk(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 10'd5, 3'd1,
                   64'hFFFF_FEFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        vt[5] = mk(1'b1, 64'hA5A5_5A5A_F0F0_0F0F, 1'b0, 1'b0, 1'b0, 10'd0, 3'd0, 64'd0, 64'd0);

        rst = 1'b1; start = 1'b0; use1k = 1'b0; fault_en = 1'b0; pattern = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst8", 0, {busy8, done8, fail8, faddr8, felem8, fdata8, fexp8}, 160'(0));
        check("rst8_pins", 0, {if8.sram_we, if8.sram_wmask, if8.sram_addr, if8.sram_din}, 160'(0));
        check("rst1k", 0, {busy1k, done1k, fail1k, faddr1k, felem1k, fdata1k, fexp1k}, 160'(0));
        check("rst1k_pins", 0, {if1k.sram_we, if1k.sram_wmask, if1k.sram_addr, if1k.sram_din}, 160'(0));
        rst = 1'b0;

        for (int k = 0; k < 6; k++) run_vec(vt[k]);

        repeat (3) @(negedge clk);
        check("done_hold", 0, 160'(m_done), 160'(1));

        // Abort in the middle of E3 (ops 40..55 for N=8), then rerun clean.
        use1k = 1'b0; fault_en = 1'b0; pattern = '0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (44) @(posedge clk);
        @(negedge clk);
        check("e3_pin", 44, {m_we, m_addr}, {1'b0, 10'd5});
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort", 0, {m_busy, m_done, m_we}, 160'(0));
        rst = 1'b0;
        run_vec(vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
